// File: rtl/dmem_bank.sv
// Data-memory bank for the MEM stage: byte/half/word accesses, misalignment
// detection, valid/ready request with a registered, back-pressurable response.
module dmem_bank #(
  parameter int unsigned DEPTH          = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            err;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ld;
  logic            unused_addr;

  // Upper address bits are deliberately ignored so accesses wrap modulo DEPTH*4.
  assign unused_addr = ^req_addr[31:AW+2];
  assign idx         = req_addr[AW+1:2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      if (state_nxt == RUN) init_done <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == CLEAR) begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (!CLEAR_ON_RESET || clr_cnt == '1) state_nxt = RUN;
    end
  end

  always_comb begin
    req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
    accept    = req_valid && req_ready;
  end

  always_comb begin
    err = 1'b0;
    be  = '0;
    wd  = req_wdata;
    case (req_size)
      2'b00: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        err = req_addr[0];
        be  = req_addr[1] ? 4'b1100 : 4'b0011;
        wd  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        err = |req_addr[1:0];
        be  = 4'b1111;
      end
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    rword = mem[idx];
    rbyte = rword[{req_addr[1:0], 3'b000} +: 8];
    rhalf = req_addr[1] ? rword[31:16] : rword[15:0];
    case (req_size)
      2'b00:   ld = req_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ld = req_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ld = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLEAR_ON_RESET && state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // A new acceptance takes priority over draining, so rsp_valid stays high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (err || req_we) ? '0 : ld;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_bank.sv
// Self-checking bench for dmem_bank (DEPTH=16): directed test-plan steps plus
// randomized traffic checked against a byte-addressed reference model.
`timescale 1ns/1ps
module tb_dmem_bank;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, init_done;
  logic [31:0] rsp_rdata;

  dmem_bank #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        has_fix;
    bit [31:0] fix;
  } op_t;

  typedef struct {
    bit        err;
    bit [31:0] rdata;
    bit        has_fix;
    bit [31:0] fix;
  } exp_t;

  op_t         pend_q[$];
  exp_t        exp_q[$];
  logic [7:0]  mb [NBYTES];
  int unsigned tests = 0;
  int unsigned failed = 0;
  bit          stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: little-endian byte array, wrap modulo bank size.
  function automatic exp_t model(input op_t o);
    exp_t        e;
    int unsigned a, n;
    bit [31:0]   v;
    a = o.addr % NBYTES;
    n = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
    e.has_fix = o.has_fix;
    e.fix     = o.fix;
    e.err     = 1'b0;
    e.rdata   = '0;
    if (o.size == 2'd3 || (a % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (o.we) begin
      for (int i = 0; i < int'(n); i++) mb[a+i] = 8'(o.wdata >> (8*i));
      return e;
    end
    v = '0;
    for (int i = 0; i < int'(n); i++) v |= 32'(mb[a+i]) << (8*i);
    if (n < 4 && !o.uns && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
    e.rdata = v;
    return e;
  endfunction

  function automatic void push(input bit we, input bit [1:0] size, input bit uns,
                               input bit [31:0] addr, input bit [31:0] wdata,
                               input bit has_fix = 1'b0, input bit [31:0] fix = '0);
    op_t o;
    o.we = we; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata;
    o.has_fix = has_fix; o.fix = fix;
    pend_q.push_back(o);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic: drive, check response/ready against the model, advance.
  task automatic cycle();
    bit exp_ready;
    rsp_ready = !stall;
    if (pend_q.size() != 0) begin
      req_valid    = 1'b1;
      req_we       = pend_q[0].we;
      req_size     = pend_q[0].size;
      req_unsigned = pend_q[0].uns;
      req_addr     = pend_q[0].addr;
      req_wdata    = pend_q[0].wdata;
    end else begin
      req_valid = 1'b0;
    end
    #1;
    exp_ready = (exp_q.size() == 0) || !stall;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
      check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
      if (exp_q[0].has_fix) check("rsp_fixed", rsp_rdata, exp_q[0].fix);
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (exp_q.size() != 0 && !stall) void'(exp_q.pop_front());
    if (req_valid && exp_ready) exp_q.push_back(model(pend_q.pop_front()));
    step();
  endtask

  task automatic drain(input int unsigned pct);
    int unsigned n = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
      stall = ($urandom_range(99) < pct);
      cycle();
      n++;
    end
    stall = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("idle_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic start_reset();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    stall     = 1'b0;
    rstn      = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    pend_q.delete();
    exp_q.delete();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic clear_check();
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("clear_ready", 32'(req_ready), 32'd0);
      check("clear_init", 32'(init_done), 32'd0);
      step();
    end
    check("run_ready", 32'(req_ready), 32'd1);
    check("run_init_done", 32'(init_done), 32'd1);
    for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset/clear, then dirty every word and confirm a second clear zeroes it.
    start_reset();
    clear_check();
    for (int i = 0; i < int'(DEPTH); i++) push(1'b1, 2'd2, 1'b0, 32'(i*4), $urandom);
    drain(0);
    start_reset();
    clear_check();
    for (int i = 0; i < int'(DEPTH); i++) push(1'b0, 2'd2, 1'b0, 32'(i*4), '0, 1'b1, 32'h0);
    drain(0);

    // Lane stores and extended loads.
    push(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344);
    push(1'b1, 2'd0, 1'b0, 32'h41, 32'h000000AB);
    push(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000BEEF);
    push(1'b0, 2'd2, 1'b0, 32'h40, '0, 1'b1, 32'hBEEFAB44);
    push(1'b0, 2'd0, 1'b0, 32'h41, '0, 1'b1, 32'hFFFFFFAB);
    push(1'b0, 2'd0, 1'b1, 32'h41, '0, 1'b1, 32'h000000AB);
    push(1'b0, 2'd1, 1'b0, 32'h42, '0, 1'b1, 32'hFFFFBEEF);
    drain(0);

    // Misaligned and illegal requests leave memory untouched.
    push(1'b1, 2'd2, 1'b0, 32'h42, 32'hDEADBEEF, 1'b1, 32'h0);
    push(1'b0, 2'd1, 1'b0, 32'h43, '0, 1'b1, 32'h0);
    push(1'b0, 2'd3, 1'b0, 32'h40, '0, 1'b1, 32'h0);
    push(1'b0, 2'd2, 1'b0, 32'h40, '0, 1'b1, 32'hBEEFAB44);
    drain(0);

    // Back-pressure: stall 3 cycles once the first response is up.
    push(1'b0, 2'd2, 1'b0, 32'h40, '0);
    push(1'b0, 2'd0, 1'b1, 32'h41, '0);
    push(1'b0, 2'd1, 1'b0, 32'h42, '0);
    push(1'b0, 2'd0, 1'b0, 32'h43, '0);
    stall = 1'b0;
    cycle();
    stall = 1'b1;
    repeat (3) cycle();
    stall = 1'b0;
    drain(0);

    // Address wrap.
    push(1'b1, 2'd2, 1'b0, 32'h00000044, 32'hCAFEF00D);
    push(1'b0, 2'd2, 1'b0, 32'h00000004, '0, 1'b1, 32'hCAFEF00D);
    drain(0);

    // Reset at clear cycle 7, then a full clear.
    start_reset();
    for (int i = 0; i < 7; i++) begin
      check("midclr_ready", 32'(req_ready), 32'd0);
      step();
    end
    start_reset();
    clear_check();
    push(1'b0, 2'd2, 1'b0, 32'h40, '0, 1'b1, 32'h0);
    drain(0);

    // Reset while a response is stalled.
    push(1'b1, 2'd2, 1'b0, 32'h44, 32'h5A5AA5A5);
    drain(0);
    push(1'b0, 2'd2, 1'b0, 32'h44, '0);
    stall = 1'b0;
    cycle();
    stall = 1'b1;
    cycle();
    check("stall_pending", 32'(rsp_valid), 32'd1);
    start_reset();
    clear_check();
    push(1'b0, 2'd2, 1'b0, 32'h44, '0, 1'b1, 32'h0);
    drain(0);

    // Randomized traffic with random back-pressure.
    repeat (300) push(1'($urandom), 2'($urandom_range(3)), 1'($urandom), $urandom, $urandom);
    drain(30);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
